// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Function : BCD tens/ones pair to binary (ten*10 + one) via an add-10 loop,
//            valid/ready on input and output. Optional digit range check is
//            enabled by defining BCD_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
   parameter int W_OUT = 7,
   parameter int W_DIG = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_DIG-1:0] ten,
   input  logic [W_DIG-1:0] one,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] n,
   output logic             busy,
   output logic             err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [W_OUT-1:0] c_ten_step = W_OUT'(10);
   localparam logic [W_DIG-1:0] c_dig_max  = W_DIG'(9);

   logic [1:0]       r_state;
   logic [W_DIG-1:0] r_cnt;
   logic [W_OUT-1:0] r_acc;
   logic [W_OUT-1:0] r_n;
   logic             r_out_valid;
   logic             w_bad;
   logic             w_accept;

   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign n         = r_n;

`ifdef BCD_RANGE_CHECK_EN
   logic r_err;

   assign w_bad = (ten > c_dig_max) || (one > c_dig_max);
   assign err   = r_err;

   // Set on a rejected request, cleared by a legal accept or the result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_bad;
      end else if ((r_state == S_DONE) && out_ready) begin
         r_err <= 1'b0;
      end
   end
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_n         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_bad) begin
                     r_state     <= S_DONE;
                     r_n         <= '0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_cnt   <= ten;
                     r_acc   <= W_OUT'(one);
                     r_state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               // cnt holds the remaining tens still to be added into acc
               if (r_cnt != '0) begin
                  r_acc <= r_acc + c_ten_step;
                  r_cnt <= r_cnt - W_DIG'(1);
               end else begin
                  r_state     <= S_DONE;
                  r_n         <= r_acc;
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
